config_latch_bank: RTL and testbench

- Parametrised configuration-memory bank: NUM_WL word lines by DATA_WIDTH bit lines of configuration storage.
- Programmed through a valid/ready request port. A sequencer drives a one-hot word-line pulse of programmable length, then returns a readback response.
- Adds a sticky lock to block reprogramming.
- Sits between the configuration protocol controller and fabric blocks; drives their SRAM inputs via Q/Qb.

---
 rtl/config_latch_bank.sv | 152 +++++++++++++++
 tb/tb_config_latch_bank.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/config_latch_bank.sv
// config_latch_bank: NUM_WL x DATA_WIDTH configuration storage bank, written one row at a time.
//
// A valid/ready request names a row and carries its bit-line data. The sequencer pulses that
// row's word line for WL_PULSE cycles and latches the data on the final pulse edge. It then
// issues a one-cycle readback response. Addresses >= NUM_WL skip the pulse and respond with
// an error. A sticky lock blocks further requests until reset.
//
// Ports:
//   prog_clk   programming clock; all state updates on its rising edge
//   reset      asynchronous active-high reset
//   prog_en    gates acceptance of new requests only
//   req_valid  / req_ready / req_addr / req_bl   write request handshake and payload
//   lock       request to lock the bank; locked is the sticky status
//   busy       operation in flight (PULSE or RESP)
//   wl_active  one-hot word line being pulsed, zero otherwise
//   rsp_valid  / rsp_err / rsp_bl   one-cycle response; rsp_bl is readback, zero on error
//   Q / Qb     stored bits (row r at [r*DATA_WIDTH +: DATA_WIDTH]) and their complement
module config_latch_bank #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_WL     = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned WL_PULSE   = 2
) (
  input  logic                         prog_clk,
  input  logic                         reset,
  input  logic                         prog_en,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_WIDTH-1:0]        req_addr,
  input  logic [DATA_WIDTH-1:0]        req_bl,
  input  logic                         lock,
  output logic                         locked,
  output logic                         busy,
  output logic [NUM_WL-1:0]            wl_active,
  output logic                         rsp_valid,
  output logic                         rsp_err,
  output logic [DATA_WIDTH-1:0]        rsp_bl,
  output logic [NUM_WL*DATA_WIDTH-1:0] Q,
  output logic [NUM_WL*DATA_WIDTH-1:0] Qb
);

  localparam int unsigned CntW = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

  typedef enum logic [1:0] {StIdle, StPulse, StResp} state_e;

  state_e                            state_q, state_d;
  logic [ADDR_WIDTH-1:0]             addr_q, addr_d;
  logic [DATA_WIDTH-1:0]             data_q, data_d;
  logic                              err_q, err_d;
  logic [CntW-1:0]                   cnt_q, cnt_d;
  logic                              locked_q;
  logic [NUM_WL-1:0][DATA_WIDTH-1:0] mem_q;

  logic accept;
  logic in_range;
  logic write_en;

  assign req_ready = (state_q == StIdle) && prog_en && !locked_q;
  assign accept    = req_valid && req_ready;
  assign in_range  = 32'(req_addr) < NUM_WL;

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    write_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d = req_addr;
          data_d = req_bl;
          if (in_range) begin
            state_d = StPulse;
            cnt_d   = CntW'(WL_PULSE - 1);
            err_d   = 1'b0;
          end else begin
            // Out-of-range: no pulse, storage untouched, respond next cycle.
            state_d = StResp;
            err_d   = 1'b1;
          end
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          write_en = 1'b1;
          state_d  = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge prog_clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      // Lock only gates new accepts; an operation accepted on the same edge still completes.
      locked_q <= locked_q | lock;
    end
  end

  // Storage: only the addressed row is written, and only on the last pulse edge.
  always_ff @(posedge prog_clk or posedge reset) begin
    if (reset) begin
      mem_q <= '0;
    end else begin
      for (int r = 0; r < int'(NUM_WL); r++) begin
        if (write_en && (addr_q == ADDR_WIDTH'(r))) begin
          mem_q[r] <= data_q;
        end
      end
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    wl_active = '0;
    rsp_bl    = '0;
    for (int r = 0; r < int'(NUM_WL); r++) begin
      if ((state_q == StPulse) && (addr_q == ADDR_WIDTH'(r))) begin
        wl_active[r] = 1'b1;
      end
      if ((state_q == StResp) && !err_q && (addr_q == ADDR_WIDTH'(r))) begin
        rsp_bl = mem_q[r];
      end
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_err   = rsp_valid && err_q;
  assign busy      = (state_q != StIdle);
  assign locked    = locked_q;
  assign Q         = mem_q;
  assign Qb        = ~mem_q;

endmodule

// File: tb/tb_config_latch_bank.sv
// Directed testbench for config_latch_bank (NUM_WL=16, DATA_WIDTH=8, ADDR_WIDTH=5, WL_PULSE=2).
// Expected storage is tracked in exp_mem and compared against Q/Qb at each response.
module tb_config_latch_bank;

  localparam int unsigned DW  = 8;
  localparam int unsigned NWL = 16;
  localparam int unsigned AW  = 5;
  localparam int unsigned WLP = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              prog_en;
  logic              req_valid;
  logic              req_ready;
  logic [AW-1:0]     req_addr;
  logic [DW-1:0]     req_bl;
  logic              lock;
  logic              locked;
  logic              busy;
  logic [NWL-1:0]    wl_active;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DW-1:0]     rsp_bl;
  logic [NWL*DW-1:0] Q;
  logic [NWL*DW-1:0] Qb;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_mem [NWL];

  config_latch_bank #(
    .DATA_WIDTH (DW),
    .NUM_WL     (NWL),
    .ADDR_WIDTH (AW),
    .WL_PULSE   (WLP)
  ) dut (
    .prog_clk  (clk),
    .reset     (reset),
    .prog_en   (prog_en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_bl    (req_bl),
    .lock      (lock),
    .locked    (locked),
    .busy      (busy),
    .wl_active (wl_active),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_bl    (rsp_bl),
    .Q         (Q),
    .Qb        (Qb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_q();
    logic [127:0] v;
    v = '0;
    for (int r = 0; r < int'(NWL); r++) v[r*DW +: DW] = exp_mem[r];
    return v;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < int'(NWL); r++) exp_mem[r] = '0;
  endtask

  // Issue one request and check every cycle through the following idle cycle.
  // Entered and left at 3 time units after a rising edge.
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic lk);
    logic          in_rng;
    logic [15:0]   onehot;
    in_rng    = addr < AW'(NWL);
    onehot    = 16'(1) << addr[3:0];
    req_valid = 1'b1;
    req_addr  = addr;
    req_bl    = data;
    lock      = lk;
    #1;
    check("ready_before_accept", 128'(req_ready), 128'(1));
    @(posedge clk); #3;
    req_valid = 1'b0;
    lock      = 1'b0;
    if (lk) check("locked_after_accept", 128'(locked), 128'(1));
    if (in_rng) begin
      for (int k = 0; k < int'(WLP); k++) begin
        check("pulse_wl_active", 128'(wl_active), 128'(onehot));
        check("pulse_busy", 128'(busy), 128'(1));
        check("pulse_ready_low", 128'(req_ready), 128'(0));
        check("pulse_no_rsp", 128'(rsp_valid), 128'(0));
        check("pulse_q_unchanged", Q, model_q());
        @(posedge clk); #3;
      end
      exp_mem[addr[3:0]] = data;
      check("rsp_valid", 128'(rsp_valid), 128'(1));
      check("rsp_err", 128'(rsp_err), 128'(0));
      check("rsp_bl", 128'(rsp_bl), 128'(data));
    end else begin
      check("oor_rsp_valid", 128'(rsp_valid), 128'(1));
      check("oor_rsp_err", 128'(rsp_err), 128'(1));
      check("oor_rsp_bl", 128'(rsp_bl), 128'(0));
    end
    check("rsp_wl_idle", 128'(wl_active), 128'(0));
    check("rsp_q", Q, model_q());
    check("rsp_qb", Qb, ~model_q());
    @(posedge clk); #3;
    check("idle_rsp_valid", 128'(rsp_valid), 128'(0));
    check("idle_rsp_err", 128'(rsp_err), 128'(0));
    check("idle_rsp_bl", 128'(rsp_bl), 128'(0));
    check("idle_busy", 128'(busy), 128'(0));
  endtask

  initial begin
    reset     = 1'b1;
    prog_en   = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_bl    = '0;
    lock      = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;

    // Reset state
    check("rst_q", Q, 128'(0));
    check("rst_qb", Qb, ~128'(0));
    check("rst_ready", 128'(req_ready), 128'(1));
    check("rst_locked", 128'(locked), 128'(0));
    check("rst_wl", 128'(wl_active), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_rsp_valid", 128'(rsp_valid), 128'(0));

    // prog_en low: valid is ignored
    prog_en   = 1'b0;
    req_valid = 1'b1;
    req_addr  = 5'd2;
    req_bl    = 8'hFF;
    repeat (3) begin
      @(posedge clk); #3;
      check("progen_low_ready", 128'(req_ready), 128'(0));
      check("progen_low_busy", 128'(busy), 128'(0));
    end
    check("progen_low_q", Q, 128'(0));
    req_valid = 1'b0;
    prog_en   = 1'b1;
    @(posedge clk); #3;

    // Single write
    do_write(5'd3, 8'hA5, 1'b0);
    check("row3_slice", 128'(Q[31:24]), 128'(8'hA5));

    // Back-to-back rows 0..15, data = row index
    for (int r = 0; r < int'(NWL); r++) do_write(AW'(r), DW'(r), 1'b0);
    check("b2b_final_q", Q, model_q());

    // Out-of-range address
    do_write(5'd20, 8'h77, 1'b0);

    // Lock on the same edge as a write to row 5
    do_write(5'd5, 8'h3C, 1'b1);
    check("lock_row5", 128'(Q[47:40]), 128'(8'h3C));
    req_valid = 1'b1;
    req_addr  = 5'd1;
    req_bl    = 8'hEE;
    repeat (20) begin
      @(posedge clk); #3;
      check("locked_ready_low", 128'(req_ready), 128'(0));
      check("locked_busy_low", 128'(busy), 128'(0));
    end
    req_valid = 1'b0;
    check("locked_sticky", 128'(locked), 128'(1));
    check("locked_q_frozen", Q, model_q());

    // Reset clears lock and storage
    reset = 1'b1;
    #1;
    clear_model();
    check("rst2_locked", 128'(locked), 128'(0));
    check("rst2_q", Q, 128'(0));
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("rst2_ready", 128'(req_ready), 128'(1));

    // Reset during the pulse of a write to row 7
    req_valid = 1'b1;
    req_addr  = 5'd7;
    req_bl    = 8'h99;
    @(posedge clk); #3;
    req_valid = 1'b0;
    check("mid_pulse_wl", 128'(wl_active), 128'(16'h0080));
    reset = 1'b1;
    #1;
    check("abort_q", Q, 128'(0));
    check("abort_wl", 128'(wl_active), 128'(0));
    check("abort_rsp_valid", 128'(rsp_valid), 128'(0));
    check("abort_locked", 128'(locked), 128'(0));
    check("abort_busy", 128'(busy), 128'(0));
    @(posedge clk); #3;
    reset = 1'b0;
    repeat (4) begin
      @(posedge clk); #3;
      check("abort_no_rsp", 128'(rsp_valid), 128'(0));
      check("abort_q_zero", Q, 128'(0));
    end
    do_write(5'd7, 8'h5A, 1'b0);
    check("row7_after_abort", 128'(Q[63:56]), 128'(8'h5A));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
